spi_slave_core: RTL and testbench

SPI slave, byte-oriented, MSB first. All logic runs in the single fabric clock i_Clk; SPI pins are synchronised and edge-detected (oversampling).
- Each received MOSI byte goes to the fabric with a one-cycle valid strobe.
- A byte loaded from the fabric is serialised onto MISO.
- Sits between an external SPI master and local register/command logic.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_slave_core_sync_2ff.sv | 21 ++
 rtl/spi_slave_core.sv | 95 +++++++++
 tb/tb_spi_slave_core.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: mode-bit positions and data widths.
package spi_pkg;
    localparam int CPOL_BIT  = 1;
    localparam int CPHA_BIT  = 0;
    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;
endpackage

// File: rtl/spi_slave_core_sync_2ff.sv
// Single-bit two-flop synchroniser with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_slave_core.sv
// Oversampling SPI slave: MSB-first byte receive to the fabric and byte serialisation onto MISO.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int SPI_MODE = 0
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_TX_DV,
    input  logic [BYTE_W-1:0] i_TX_Byte,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_MOSI,
    input  logic              i_SPI_CS_n,
    output logic              o_RX_DV,
    output logic [BYTE_W-1:0] o_RX_Byte,
    output logic              o_SPI_MISO
);
    localparam logic [1:0] MODE = 2'(SPI_MODE);
    localparam logic       CPOL = MODE[CPOL_BIT];
    localparam logic       CPHA = MODE[CPHA_BIT];

    logic                 cs_s, sclk_s, mosi_s;
    logic                 cs_q, sclk_q;
    logic                 cs_fall, active, lead_edge, trail_edge;
    logic                 sample_edge, shift_edge;
    logic [BYTE_W-1:0]    tx_hold, tx_next, tx_shift, rx_shift;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 miso_en;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(i_Clk), .rst_n(i_Rst_L), .d(i_SPI_CS_n), .q(cs_s));
    sync_2ff #(.RST_VAL(CPOL)) u_sync_sclk (.clk(i_Clk), .rst_n(i_Rst_L), .d(i_SPI_Clk),  .q(sclk_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(i_Clk), .rst_n(i_Rst_L), .d(i_SPI_MOSI), .q(mosi_s));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cs_q   <= 1'b1;
            sclk_q <= CPOL;
        end else begin
            cs_q   <= cs_s;
            sclk_q <= sclk_s;
        end
    end

    // Edges only count once CS has been low for a full cycle.
    assign cs_fall     = cs_q & ~cs_s;
    assign active      = ~cs_q & ~cs_s;
    assign lead_edge   = active & (sclk_q == CPOL) & (sclk_s != CPOL);
    assign trail_edge  = active & (sclk_q != CPOL) & (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    // A load in the same cycle as a reload is bypassed straight into the shifter.
    assign tx_next = i_TX_DV ? i_TX_Byte : tx_hold;

    // o_RX_DV is a one-cycle strobe with no back-pressure: the fabric takes o_RX_Byte when it is high.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_hold   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            o_RX_Byte <= '0;
            o_RX_DV   <= 1'b0;
            miso_en   <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            miso_en <= ~cs_s;
            if (i_TX_DV) tx_hold <= i_TX_Byte;

            if (cs_s) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (cs_fall) begin
                bit_cnt  <= '0;
                tx_shift <= tx_next;
            end else begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[BYTE_W-2:0], mosi_s};
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
                        o_RX_Byte <= {rx_shift[BYTE_W-2:0], mosi_s};
                        o_RX_DV   <= 1'b1;
                    end
                end
                // A shift edge at count zero starts a new byte on MISO.
                if (shift_edge) begin
                    if (bit_cnt == '0) tx_shift <= tx_next;
                    else               tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                end
            end
        end
    end

    assign o_SPI_MISO = miso_en ? tx_shift[BYTE_W-1] : 1'bz;
endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core in mode 0 and mode 3 with an RX byte scoreboard.
module tb_spi_slave_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       sclk0 = 1'b0, cs0_n = 1'b1;
    logic       sclk3 = 1'b1, cs3_n = 1'b1;
    logic       mosi = 1'b0;
    logic       rx_dv0, rx_dv3;
    logic [7:0] rx_byte0, rx_byte3;
    wire        miso0, miso3;

    int         cmp_cnt = 0;
    int         fail_cnt = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q3[$];
    logic [7:0] exp0, exp3;

    spi_slave_core #(.SPI_MODE(0)) dut0 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_DV(tx_dv), .i_TX_Byte(tx_byte),
        .i_SPI_Clk(sclk0), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs0_n),
        .o_RX_DV(rx_dv0), .o_RX_Byte(rx_byte0), .o_SPI_MISO(miso0)
    );

    spi_slave_core #(.SPI_MODE(3)) dut3 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_DV(tx_dv), .i_TX_Byte(tx_byte),
        .i_SPI_Clk(sclk3), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs3_n),
        .o_RX_DV(rx_dv3), .o_RX_Byte(rx_byte3), .o_SPI_MISO(miso3)
    );

    // Clock / reset: 100 MHz fabric clock, posedges at 5, 15, 25 ns ...
    always #5 clk = ~clk;

    // Scoreboard: every RX strobe pops one expected byte.
    always @(negedge clk) begin
        if (rst_n && rx_dv0) begin
            cmp_cnt++;
            assert (exp_q0.size() != 0) else begin
                fail_cnt++;
                $error("FAIL rx0_unexpected_dv: observed=%h expected=no strobe", rx_byte0);
            end
            if (exp_q0.size() != 0) begin
                exp0 = exp_q0.pop_front();
                assert (rx_byte0 === exp0) else begin
                    fail_cnt++;
                    $error("FAIL rx0_byte: observed=%h expected=%h", rx_byte0, exp0);
                end
            end
        end
        if (rst_n && rx_dv3) begin
            cmp_cnt++;
            assert (exp_q3.size() != 0) else begin
                fail_cnt++;
                $error("FAIL rx3_unexpected_dv: observed=%h expected=no strobe", rx_byte3);
            end
            if (exp_q3.size() != 0) begin
                exp3 = exp_q3.pop_front();
                assert (rx_byte3 === exp3) else begin
                    fail_cnt++;
                    $error("FAIL rx3_byte: observed=%h expected=%h", rx_byte3, exp3);
                end
            end
        end
    end

    task automatic chk_bit(input string tag, input logic act, input logic exp);
        cmp_cnt++;
        assert (act === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed=%b expected=%b", tag, act, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] act, input logic [7:0] exp);
        cmp_cnt++;
        assert (act === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic chk_z(input string tag, input logic is_z, input logic act);
        cmp_cnt++;
        assert (is_z === 1'b1) else begin
            fail_cnt++;
            $error("FAIL %s: observed=%b expected=z", tag, act);
        end
    endtask

    task automatic pulse_tx(input logic [7:0] b);
        tx_byte = b;
        tx_dv   = 1'b1;
        #10;
        tx_dv   = 1'b0;
    endtask

    // Master driver: 10 MHz SCLK; MISO is checked 5 ns before each sample edge.
    task automatic xfer(input bit m3, input logic [7:0] mo, input logic [7:0] mi,
                        input int nbits, input string tag);
        for (int i = 0; i < nbits; i++) begin
            if (m3) sclk3 = 1'b0;
            mosi = mo[7-i];
            #45;
            if (m3) chk_bit($sformatf("%s_miso_b%0d", tag, i), miso3, mi[7-i]);
            else    chk_bit($sformatf("%s_miso_b%0d", tag, i), miso0, mi[7-i]);
            #5;
            if (m3) sclk3 = 1'b1;
            else    sclk0 = 1'b1;
            #50;
            if (!m3) sclk0 = 1'b0;
        end
    endtask

    initial begin
        // 1: reset
        #1 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        #1;
        chk_bit("t1_rx_dv0", rx_dv0, 1'b0);
        chk8("t1_rx_byte0", rx_byte0, 8'h00);
        chk_z("t1_miso0", miso0 === 1'bz, miso0);
        chk_z("t1_miso3", miso3 === 1'bz, miso3);
        @(posedge clk);
        #7;

        // 2: mode 0 single byte
        pulse_tx(8'hAA);
        #20;
        cs0_n = 1'b0;
        exp_q0.push_back(8'h3C);
        xfer(1'b0, 8'h3C, 8'hAA, 8, "t2");
        #50 cs0_n = 1'b1;
        #100;
        chk_z("t2_miso_idle", miso0 === 1'bz, miso0);

        // 3: back-to-back bytes with TX valid held high
        tx_byte = 8'hAA;
        tx_dv   = 1'b1;
        #20;
        cs0_n = 1'b0;
        exp_q0.push_back(8'h5A);
        exp_q0.push_back(8'hC3);
        xfer(1'b0, 8'h5A, 8'hAA, 8, "t3a");
        xfer(1'b0, 8'hC3, 8'hAA, 8, "t3b");
        #50 cs0_n = 1'b1;
        tx_dv = 1'b0;
        #100;

        // 4: CS raised after 5 bits, then a full frame
        cs0_n = 1'b0;
        xfer(1'b0, 8'hFF, 8'hAA, 5, "t4p");
        #50 cs0_n = 1'b1;
        #50;
        chk_z("t4_miso_abort", miso0 === 1'bz, miso0);
        chk8("t4_rx_held", rx_byte0, 8'hC3);
        #100 cs0_n = 1'b0;
        exp_q0.push_back(8'h81);
        xfer(1'b0, 8'h81, 8'hAA, 8, "t4");
        #50 cs0_n = 1'b1;
        #100;

        // 5: mode 3
        pulse_tx(8'h96);
        #20;
        cs3_n = 1'b0;
        #50;
        exp_q3.push_back(8'h69);
        xfer(1'b1, 8'h69, 8'h96, 8, "t5");
        #50 cs3_n = 1'b1;
        #100;
        chk_z("t5_miso3_idle", miso3 === 1'bz, miso3);
        chk_z("t5_miso0_idle", miso0 === 1'bz, miso0);

        // 6: reset mid-byte, then a clean frame
        pulse_tx(8'h33);
        #20;
        cs0_n = 1'b0;
        xfer(1'b0, 8'hF0, 8'h33, 4, "t6p");
        #20 rst_n = 1'b0;
        #1;
        chk_z("t6_miso_rst", miso0 === 1'bz, miso0);
        chk_bit("t6_rx_dv_rst", rx_dv0, 1'b0);
        chk8("t6_rx_byte0_rst", rx_byte0, 8'h00);
        chk8("t6_rx_byte3_rst", rx_byte3, 8'h00);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #7;
        cs0_n = 1'b1;
        #100;
        pulse_tx(8'h7E);
        #20;
        cs0_n = 1'b0;
        exp_q0.push_back(8'hE7);
        xfer(1'b0, 8'hE7, 8'h7E, 8, "t6");
        #50 cs0_n = 1'b1;
        #200;

        // Final report: all expected bytes must have been delivered.
        cmp_cnt++;
        assert (exp_q0.size() == 0) else begin
            fail_cnt++;
            $error("FAIL rx0_missing: observed=%0d pending expected=0", exp_q0.size());
        end
        cmp_cnt++;
        assert (exp_q3.size() == 0) else begin
            fail_cnt++;
            $error("FAIL rx3_missing: observed=%0d pending expected=0", exp_q3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule
